// File: rtl/adrv9009_tifc.sv
// ADRV9009 transmit interface: 55-tap half-band interpolate-by-2 FIR in polyphase form.
// Define ADRV9009_TIFC_SAT_EN to saturate the output instead of wrapping.
module adrv9009_tifc (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               underflow,
    input  logic               underflow_clr
);

    // Non-zero even-phase taps h[0..54 step 2]; the odd phase is the single center tap 16384.
    localparam logic signed [15:0] H [0:27] = '{
        -16'sd3,    16'sd7,    -16'sd18,   16'sd39,   -16'sd75,   16'sd131,  -16'sd212,
         16'sd337, -16'sd514,   16'sd773, -16'sd1169,  16'sd1844, -16'sd3325,  16'sd10380,
         16'sd10380, -16'sd3325, 16'sd1844, -16'sd1169, 16'sd773, -16'sd514,  16'sd337,
        -16'sd212,  16'sd131,  -16'sd75,   16'sd39,   -16'sd18,   16'sd7,    -16'sd3
    };

    typedef enum logic {
        PH_LOAD = 1'b0,
        PH_CALC = 1'b1
    } phase_t;

    phase_t             phase;
    phase_t             phase_nxt;
    logic        [2:0]  warm_cnt;
    logic signed [15:0] x    [0:27];
    logic signed [31:0] prod [0:27];
    logic signed [36:0] s1   [0:13];
    logic signed [36:0] s2   [0:6];
    logic signed [36:0] s3   [0:3];
    logic signed [36:0] s4   [0:1];
    logic signed [36:0] s5;
    logic signed [15:0] result;

    // Handshake: a sample moves when in_valid && in_ready; in_ready is high every other
    // clock and never waits on in_valid, so a missing sample is replaced by zero.
    assign in_ready = reset && (phase == PH_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) phase <= PH_LOAD;
        else        phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = PH_LOAD;
        case (phase)
            PH_LOAD: phase_nxt = PH_CALC;
            PH_CALC: phase_nxt = PH_LOAD;
            default: phase_nxt = PH_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < 28; j++) x[j] <= '0;
        end else if (in_ready) begin
            x[0] <= in_valid ? in : 16'sd0;
            for (int j = 1; j < 28; j++) x[j] <= x[j-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    underflow <= 1'b0;
        else if (in_ready && !in_valid) underflow <= 1'b1;
        else if (underflow_clr)        underflow <= 1'b0;
    end

    // The clock right after a shift computes the even phase, the next one the odd phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < 28; j++) prod[j] <= '0;
        end else begin
            for (int j = 0; j < 28; j++) begin
                if (phase == PH_CALC) prod[j] <= 32'(x[j]) * 32'(H[j]);
                else if (j == 13)     prod[j] <= 32'(x[j]) <<< 14;
                else                  prod[j] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 14; i++) s1[i] <= '0;
            for (int i = 0; i < 7; i++)  s2[i] <= '0;
            for (int i = 0; i < 4; i++)  s3[i] <= '0;
            for (int i = 0; i < 2; i++)  s4[i] <= '0;
            s5 <= '0;
        end else begin
            for (int i = 0; i < 14; i++) s1[i] <= 37'(prod[2*i]) + 37'(prod[2*i+1]);
            for (int i = 0; i < 7; i++)  s2[i] <= s1[2*i] + s1[2*i+1];
            for (int i = 0; i < 3; i++)  s3[i] <= s2[2*i] + s2[2*i+1];
            s3[3] <= s2[6];
            for (int i = 0; i < 2; i++)  s4[i] <= s3[2*i] + s3[2*i+1];
            s5 <= s4[0] + s4[1];
        end
    end

`ifdef ADRV9009_TIFC_SAT_EN
    logic signed [36:0] shifted;

    always_comb begin
        shifted = s5 >>> 14;
        result  = shifted[15:0];
        if (shifted > 37'sd32767)       result = 16'sh7FFF;
        else if (shifted < -37'sd32768) result = 16'sh8000;
    end
`else
    logic unused_acc_bits;

    assign result          = s5[29:14];
    assign unused_acc_bits = ^{s5[36:30], s5[13:0]};
`endif

    // Seven clocks of pipeline fill after release before the first real result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            if (warm_cnt != 3'd7) warm_cnt <= warm_cnt + 3'd1;
            out_valid <= (warm_cnt == 3'd7);
            if (warm_cnt == 3'd7) out <= result;
        end
    end

endmodule

// File: tb/tb_adrv9009_tifc.sv
// Directed bench for adrv9009_tifc: impulse, DC, overload, underflow and mid-stream reset.
module tb_adrv9009_tifc;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out;
    logic               out_valid;
    logic               underflow;
    logic               underflow_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0]        stim_q[$];
    logic signed [15:0] got_q[$];
    logic signed [15:0] exp_q[$];

    localparam int H_TAB [0:13] = '{-3, 7, -18, 39, -75, 131, -212, 337, -514, 773,
                                    -1169, 1844, -3325, 10380};

    adrv9009_tifc dut (
        .clk           (clk),
        .reset         (reset),
        .in            (in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out           (out),
        .out_valid     (out_valid),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    function automatic int h(input int j);
        if (j < 14) return H_TAB[j];
        return H_TAB[27-j];
    endfunction

    function automatic logic signed [31:0] got_at(input int idx);
        if (idx < got_q.size()) return 32'(got_q[idx]);
        return 'x;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive();
        logic [16:0] v;
        if (in_ready) begin
            if (stim_q.size() > 0) v = stim_q.pop_front();
            else                   v = {1'b1, 16'h0000};
            in_valid = v[16];
            in       = v[15:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid) got_q.push_back(out);
        drive();
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        reset         = 1'b0;
        in_valid      = 1'b0;
        in            = '0;
        underflow_clr = 1'b0;
        stim_q.delete();
        got_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
        drive();
    endtask

    initial begin
        int nz;
        int gaps;

        reset         = 1'b0;
        in            = '0;
        in_valid      = 1'b0;
        underflow_clr = 1'b0;

        // reset state
        assert_reset();
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_underflow", underflow, 0);

        // impulse
        stim_q.push_back({1'b1, 16'h4000});
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("warm_valid_%0d", i), out_valid, (i >= 8) ? 1 : 0);
            check($sformatf("in_ready_%0d", i), in_ready, (i % 2 == 0) ? 1 : 0);
        end
        check("lat_even0", out, -3);
        repeat (72) step();
        exp_q.delete();
        for (int m = 0; m < 30; m++) begin
            exp_q.push_back((m < 28) ? 16'(h(m)) : 16'sd0);
            exp_q.push_back((m == 13) ? 16'sh4000 : 16'sd0);
        end
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("imp_%0d", i), got_at(i), exp_q[i]);
        check("imp_underflow", underflow, 0);

        // DC
        assert_reset();
        for (int i = 0; i < 60; i++) stim_q.push_back({1'b1, 16'h1000});
        release_reset();
        gaps = 0;
        for (int i = 1; i <= 90; i++) begin
            step();
            if (i >= 8 && !out_valid) gaps++;
        end
        check("dc_valid_gaps", gaps, 0);
        check("dc_even_30", got_at(60), 4097);
        check("dc_odd_30",  got_at(61), 4096);
        check("dc_even_35", got_at(70), 4097);
        check("dc_odd_35",  got_at(71), 4096);

        // overload
        assert_reset();
        for (int i = 0; i < 28; i++)
            stim_q.push_back({1'b1, (h(i) > 0) ? 16'h7FFF : 16'h8000});
        release_reset();
        repeat (66) step();
`ifdef ADRV9009_TIFC_SAT_EN
        check("ovl_even", got_at(54), 32767);
`else
        check("ovl_even", got_at(54), 9770);
`endif
        check("ovl_odd", got_at(55), 32767);

        // underflow
        assert_reset();
        stim_q.push_back({1'b1, 16'd100});
        stim_q.push_back({1'b1, 16'd200});
        stim_q.push_back({1'b0, 16'd0});
        stim_q.push_back({1'b1, 16'd300});
        release_reset();
        repeat (4) step();
        check("uf_before", underflow, 0);
        step();
        check("uf_set", underflow, 1);
        repeat (36) step();
        check("uf_odd13", got_at(27), 100);
        check("uf_odd14", got_at(29), 200);
        check("uf_odd15", got_at(31), 0);
        check("uf_odd16", got_at(33), 300);
        check("uf_sticky", underflow, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clr", underflow, 0);
        for (int i = 0; i < 4; i++) begin
            if (in_ready) break;
            step();
        end
        check("uf_slot", in_ready, 1);
        in_valid      = 1'b0;
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_set_wins", underflow, 1);
        step();
        check("uf_hold", underflow, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clr2", underflow, 0);

        // reset mid-stream during an impulse
        assert_reset();
        stim_q.push_back({1'b1, 16'h4000});
        release_reset();
        repeat (12) step();
        check("mid_pre_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_out",       out,       0);
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready",  in_ready,  0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_hold_valid", out_valid, 0);
        stim_q.delete();
        got_q.delete();
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i >= 7) check($sformatf("mid_warm_%0d", i), out_valid, (i >= 8) ? 1 : 0);
        end
        repeat (60) step();
        nz = 0;
        foreach (got_q[i]) if (got_q[i] !== 16'sd0) nz++;
        check("mid_count", (got_q.size() >= 60) ? 1 : 0, 1);
        check("mid_stale", nz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
